// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : writeback_arbiter
// Purpose  : Per-source result queues (ALU/LSU/BR) with round-robin retirement
//            into a single registered register-file write-back port.
//            Optional same-cycle bypass when idle: define WB_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module writeback_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            alu_v_i,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  output logic            alu_ok_o,
  input  logic            lsu_v_i,
  input  logic [4:0]      lsu_rd_i,
  input  logic [XLEN-1:0] lsu_data_i,
  output logic            lsu_ok_o,
  input  logic            br_v_i,
  input  logic [4:0]      br_rd_i,
  input  logic [XLEN-1:0] br_data_i,
  output logic            br_ok_o,
  output logic            res_v,
  output logic [4:0]      res_adr,
  output logic [XLEN-1:0] res_data
);

  localparam int NSRC = 3;
  localparam int AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LSU = 2'd1,
    SRC_BR  = 2'd2
  } src_e;

  function automatic src_e next_src(input src_e s);
    case (s)
      SRC_ALU: return SRC_LSU;
      SRC_LSU: return SRC_BR;
      default: return SRC_ALU;
    endcase
  endfunction

  logic [NSRC-1:0]           in_v;
  logic [NSRC-1:0][4:0]      in_rd;
  logic [NSRC-1:0][XLEN-1:0] in_data;

  logic [NSRC-1:0]           full;
  logic [NSRC-1:0]           empty;
  logic [NSRC-1:0]           push;
  logic [NSRC-1:0]           pop;
  logic [NSRC-1:0]           byp_sel;
  logic [NSRC-1:0][4:0]      head_rd;
  logic [NSRC-1:0][XLEN-1:0] head_data;

  src_e            last_src;
  logic            grant;
  src_e            gnt_src;
  logic            byp;
  src_e            byp_src;
  logic            take;
  src_e            take_src;
  logic [4:0]      take_rd;
  logic [XLEN-1:0] take_data;

  assign in_v    = {br_v_i, lsu_v_i, alu_v_i};
  assign in_rd   = {br_rd_i, lsu_rd_i, alu_rd_i};
  assign in_data = {br_data_i, lsu_data_i, alu_data_i};

  // ok depends only on queue occupancy, never on the incoming valid.
  assign alu_ok_o = !full[SRC_ALU];
  assign lsu_ok_o = !full[SRC_LSU];
  assign br_ok_o  = !full[SRC_BR];

  generate
    for (genvar g = 0; g < NSRC; g++) begin : g_queue
      logic [4:0]      mem_rd   [DEPTH];
      logic [XLEN-1:0] mem_data [DEPTH];
      logic [AW-1:0]   wr_ptr;
      logic [AW-1:0]   rd_ptr;
      logic [AW:0]     count;

      assign full[g]      = (count == FULL_CNT);
      assign empty[g]     = (count == '0);
      assign push[g]      = in_v[g] && !full[g] && !flush && !byp_sel[g];
      assign head_rd[g]   = mem_rd[rd_ptr];
      assign head_data[g] = mem_data[rd_ptr];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else if (flush) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (push[g]) wr_ptr <= wr_ptr + 1'b1;
          if (pop[g])  rd_ptr <= rd_ptr + 1'b1;
          case ({push[g], pop[g]})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
          endcase
        end
      end

      // Storage needs no reset: entries are only observed through count.
      always_ff @(posedge clk) begin
        if (push[g]) begin
          mem_rd[wr_ptr]   <= in_rd[g];
          mem_data[wr_ptr] <= in_data[g];
        end
      end
    end
  endgenerate

  // Round-robin search starts at the source after the last one granted.
  always_comb begin
    src_e cand;
    grant   = 1'b0;
    gnt_src = last_src;
    cand    = next_src(last_src);
    for (int k = 0; k < NSRC; k++) begin
      if (!grant && !empty[cand]) begin
        grant   = 1'b1;
        gnt_src = cand;
      end
      cand = next_src(cand);
    end
    if (flush) grant = 1'b0;
  end

  always_comb begin
    pop = '0;
    if (grant) pop[gnt_src] = 1'b1;
  end

`ifdef WB_BYPASS_EN
  // Idle fast path: the first valid input in RR order skips its queue.
  always_comb begin
    src_e cand;
    byp     = 1'b0;
    byp_src = last_src;
    cand    = next_src(last_src);
    if ((&empty) && !flush) begin
      for (int k = 0; k < NSRC; k++) begin
        if (!byp && in_v[cand]) begin
          byp     = 1'b1;
          byp_src = cand;
        end
        cand = next_src(cand);
      end
    end
  end
`else
  assign byp     = 1'b0;
  assign byp_src = last_src;
`endif

  always_comb begin
    byp_sel = '0;
    if (byp) byp_sel[byp_src] = 1'b1;
  end

  assign take      = grant || byp;
  assign take_src  = byp ? byp_src : gnt_src;
  assign take_rd   = byp ? in_rd[byp_src]   : head_rd[gnt_src];
  assign take_data = byp ? in_data[byp_src] : head_data[gnt_src];

  // x0 results still consume the grant but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_v    <= 1'b0;
      res_adr  <= '0;
      res_data <= '0;
      last_src <= SRC_ALU;
    end else begin
      res_v <= 1'b0;
      if (!flush && take) begin
        last_src <= take_src;
        if (take_rd != 5'd0) begin
          res_v    <= 1'b1;
          res_adr  <= take_rd;
          res_data <= take_data;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// Directed self-checking bench for writeback_arbiter (default build, no bypass).
module tb_writeback_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            alu_v_i, lsu_v_i, br_v_i;
  logic [4:0]      alu_rd_i, lsu_rd_i, br_rd_i;
  logic [XLEN-1:0] alu_data_i, lsu_data_i, br_data_i;
  logic            alu_ok_o, lsu_ok_o, br_ok_o;
  logic            res_v;
  logic [4:0]      res_adr;
  logic [XLEN-1:0] res_data;

  int tests = 0;
  int fails = 0;

  writeback_arbiter #(.XLEN(XLEN), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alu_v_i(alu_v_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i), .alu_ok_o(alu_ok_o),
    .lsu_v_i(lsu_v_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i), .lsu_ok_o(lsu_ok_o),
    .br_v_i(br_v_i), .br_rd_i(br_rd_i), .br_data_i(br_data_i), .br_ok_o(br_ok_o),
    .res_v(res_v), .res_adr(res_adr), .res_data(res_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_v_i = 1'b0; lsu_v_i = 1'b0; br_v_i = 1'b0;
    alu_rd_i = '0; lsu_rd_i = '0; br_rd_i = '0;
    alu_data_i = '0; lsu_data_i = '0; br_data_i = '0;
  endtask

  function automatic logic [2:0] oks();
    return {br_ok_o, lsu_ok_o, alu_ok_o};
  endfunction

  // Expected per-edge results for the three-source fairness burst (edges 1..10).
  logic       fair_v   [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  logic [4:0] fair_adr [10] = '{0, 1, 2, 3, 1, 2, 3, 1, 2, 0};
  logic [2:0] fair_ok  [10] = '{3'b111, 3'b001, 3'b010, 3'b100, 3'b101,
                                3'b111, 3'b111, 3'b111, 3'b111, 3'b111};

  initial begin
    logic [XLEN-1:0] exp_d;
    logic            seen;

    rst_n = 1'b0; flush = 1'b0;
    idle();
    #1;
    check("rst_res_v", res_v, 0);
    check("rst_res_adr", res_adr, 0);
    check("rst_res_data", res_data, 0);
    check("rst_ok", oks(), 3'b111);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single ALU result, two-cycle latency.
    alu_v_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEADBEEF;
    tick();
    idle();
    check("single_lat1_v", res_v, 0);
    tick();
    check("single_v", res_v, 1);
    check("single_adr", res_adr, 5);
    check("single_data", res_data, 32'hDEADBEEF);
    tick();
    check("single_drop_v", res_v, 0);
    check("single_hold_adr", res_adr, 5);

    // Park the RR pointer on BR so the burst starts at ALU.
    br_v_i = 1'b1; br_rd_i = 5'd20; br_data_i = 32'h20;
    tick();
    idle();
    tick();
    check("br_prime_adr", res_adr, 20);
    check("br_prime_v", res_v, 1);

    // Fairness and back-pressure: all three valid for four edges.
    alu_rd_i = 5'd1; alu_data_i = 32'hA1;
    lsu_rd_i = 5'd2; lsu_data_i = 32'hB2;
    br_rd_i  = 5'd3; br_data_i  = 32'hC3;
    alu_v_i = 1'b1; lsu_v_i = 1'b1; br_v_i = 1'b1;
    check("fair_ok_pre", oks(), 3'b111);
    for (int e = 0; e < 10; e++) begin
      tick();
      if (e == 3) begin
        alu_v_i = 1'b0; lsu_v_i = 1'b0; br_v_i = 1'b0;
      end
      check($sformatf("fair_v_e%0d", e + 1), res_v, fair_v[e]);
      check($sformatf("fair_ok_e%0d", e + 1), oks(), fair_ok[e]);
      if (fair_v[e]) begin
        exp_d = (fair_adr[e] == 5'd1) ? 32'hA1 : (fair_adr[e] == 5'd2) ? 32'hB2 : 32'hC3;
        check($sformatf("fair_adr_e%0d", e + 1), res_adr, fair_adr[e]);
        check($sformatf("fair_data_e%0d", e + 1), res_data, exp_d);
      end
    end
    idle();

    // rd==0 is consumed silently; the next ALU result still retires.
    lsu_v_i = 1'b1; lsu_rd_i = 5'd0; lsu_data_i = 32'h1234;
    tick();
    idle();
    check("x0_v_e1", res_v, 0);
    alu_v_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 32'h77;
    tick();
    idle();
    check("x0_v_e2", res_v, 0);
    tick();
    check("x0_next_v", res_v, 1);
    check("x0_next_adr", res_adr, 7);
    check("x0_next_data", res_data, 32'h77);

    // Flush with ALU holding two entries and a fresh LSU input.
    alu_v_i = 1'b1; alu_rd_i = 5'd10; alu_data_i = 32'h10A;
    br_v_i  = 1'b1; br_rd_i  = 5'd12; br_data_i  = 32'h10C;
    tick();
    idle();
    alu_v_i = 1'b1; alu_rd_i = 5'd11; alu_data_i = 32'h10B;
    tick();
    idle();
    check("fl_pre_adr", res_adr, 12);
    check("fl_pre_ok", oks(), 3'b110);
    flush = 1'b1;
    lsu_v_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'h109;
    #1;
    check("fl_cycle_ok", oks(), 3'b110);
    tick();
    flush = 1'b0;
    idle();
    check("fl_post_v", res_v, 0);
    check("fl_post_ok", oks(), 3'b111);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fl_idle_v", res_v, 0);
    end

    // Pointer wrap: six back-to-back ALU results.
    for (int i = 1; i <= 6; i++) begin
      alu_v_i = 1'b1; alu_rd_i = 5'(i); alu_data_i = 32'h200 + i;
      check("wrap_ok", alu_ok_o, 1);
      tick();
      if (i >= 2) begin
        check("wrap_v", res_v, 1);
        check("wrap_adr", res_adr, i - 1);
        check("wrap_data", res_data, 32'h200 + i - 1);
      end
    end
    idle();
    tick();
    check("wrap_last_adr", res_adr, 6);
    check("wrap_last_data", res_data, 32'h206);
    tick();
    check("wrap_end_v", res_v, 0);

    // Asynchronous reset in the middle of a burst.
    alu_v_i = 1'b1; alu_rd_i = 5'd21; alu_data_i = 32'h321;
    lsu_v_i = 1'b1; lsu_rd_i = 5'd22; lsu_data_i = 32'h322;
    br_v_i  = 1'b1; br_rd_i  = 5'd23; br_data_i  = 32'h323;
    tick();
    tick();
    check("ar_pre_v", res_v, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_v", res_v, 0);
    check("ar_adr", res_adr, 0);
    check("ar_data", res_data, 0);
    check("ar_ok", oks(), 3'b111);
    idle();
    tick();
    #3;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (res_v) seen = 1'b1;
    end
    check("ar_no_stale", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
